// File: rtl/vga_layer_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the VGA layer arbiter.
// Layer indices double as bit positions in the enable and data-valid vectors.
package vga_layer_arbiter_pkg;

  localparam logic [3:0] STATE_LOGO = 4'b0000;

  localparam logic [1:0] LAYER_FRAMES  = 2'd0;
  localparam logic [1:0] LAYER_BOARD   = 2'd1;
  localparam logic [1:0] LAYER_TEXT    = 2'd2;
  localparam logic [1:0] LAYER_PREVIEW = 2'd3;

  // Slot 0 (bits [1:0]) is the highest priority.
  localparam logic [7:0] DEFAULT_PRIO = {LAYER_PREVIEW, LAYER_TEXT, LAYER_BOARD, LAYER_FRAMES};

  localparam int H_ACTIVE_DEFAULT = 800;
  localparam int V_ACTIVE_DEFAULT = 600;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  function automatic logic prio_is_perm(input logic [7:0] prio);
    logic [3:0] seen;
    seen = '0;
    for (int s = 0; s < 4; s++) seen[prio[2*s +: 2]] = 1'b1;
    return &seen;
  endfunction

endpackage

// File: rtl/vga_layer_arbiter_prio_select.sv
// Combinational winner search: the first slot whose layer is eligible wins.
module layer_prio_select
  import vga_layer_arbiter_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [7:0] prio,
  output logic       found,
  output logic [1:0] winner
);

  always_comb begin
    found  = 1'b0;
    winner = LAYER_FRAMES;
    for (int s = 0; s < 4; s++) begin
      if (!found && eligible[prio[2*s +: 2]]) begin
        found  = 1'b1;
        winner = prio[2*s +: 2];
      end
    end
  end

endmodule

// File: rtl/vga_layer_arbiter.sv
// Four-layer pixel arbiter with frame-synchronous config shadowing and layer blink.
// Output pixel is registered one cycle after x/y and the layer inputs.
module vga_layer_arbiter
  import vga_layer_arbiter_pkg::*;
#(
  parameter int         H_ACTIVE     = H_ACTIVE_DEFAULT,
  parameter int         V_ACTIVE     = V_ACTIVE_DEFAULT,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [3:0] BLINK_MASK   = 4'b0100
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic [3:0]  game_state,
  input  logic [1:0]  l0_r, l0_g, l0_b,
  input  logic        l0_dav,
  input  logic [1:0]  l1_r, l1_g, l1_b,
  input  logic        l1_dav,
  input  logic [1:0]  l2_r, l2_g, l2_b,
  input  logic        l2_dav,
  input  logic [1:0]  l3_r, l3_g, l3_b,
  input  logic        l3_dav,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_en,
  input  logic [7:0]  cfg_prio,
  input  logic        blink_en,
  output logic [1:0]  r, g, b,
  output logic        dav,
  output logic        frame_tick,
  output logic        cfg_err,
  output cfg_state_e  state_dbg
);

  localparam int          CNT_W      = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);

  cfg_state_e       state_q, state_d;
  logic             frame_start, xfer, apply;
  logic [3:0]       pend_en, act_en;
  logic [7:0]       pend_prio, act_prio;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;
  logic [3:0]       dav_vec, layer_mask, eligible;
  logic             found, in_active;
  logic [1:0]       winner;
  logic [5:0]       win_rgb;

  assign frame_start = (x == '0) && (y == '0);
  assign state_dbg   = state_q;

  // cfg handshake: a word transfers on any cycle with cfg_valid && cfg_ready;
  // cfg_ready stays low from the transfer until the next frame start applies it.
  assign cfg_ready = (state_q == CFG_IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign apply     = (state_q == CFG_PENDING) && frame_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_IDLE:    if (xfer) state_d = CFG_PENDING;
      CFG_PENDING: if (frame_start) state_d = CFG_IDLE;
      default:     state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (rst) state_q <= CFG_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      pend_en   <= 4'b1111;
      pend_prio <= DEFAULT_PRIO;
    end else if (xfer) begin
      pend_en   <= cfg_en;
      pend_prio <= cfg_prio;
    end
  end

  // A malformed priority word falls back to the default order but keeps its enables.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      act_en   <= 4'b1111;
      act_prio <= DEFAULT_PRIO;
      cfg_err  <= 1'b0;
    end else if (apply) begin
      act_en <= pend_en;
      if (prio_is_perm(pend_prio)) begin
        act_prio <= pend_prio;
      end else begin
        act_prio <= DEFAULT_PRIO;
        cfg_err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst || !blink_en) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    layer_mask = act_en;
    if (blink_en && !blink_phase) layer_mask = layer_mask & ~BLINK_MASK;
    if (game_state == STATE_LOGO) layer_mask[LAYER_BOARD] = 1'b0;
  end

  assign dav_vec  = {l3_dav, l2_dav, l1_dav, l0_dav};
  assign eligible = layer_mask & dav_vec;

  layer_prio_select u_prio_select (
    .eligible (eligible),
    .prio     (act_prio),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    case (winner)
      LAYER_FRAMES: win_rgb = {l0_r, l0_g, l0_b};
      LAYER_BOARD:  win_rgb = {l1_r, l1_g, l1_b};
      LAYER_TEXT:   win_rgb = {l2_r, l2_g, l2_b};
      default:      win_rgb = {l3_r, l3_g, l3_b};
    endcase
  end

  assign in_active = (x < H_LIM) && (y < V_LIM);

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      {r, g, b}  <= '0;
      dav        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (in_active && found) begin
        {r, g, b} <= win_rgb;
        dav       <= 1'b1;
      end else begin
        {r, g, b} <= '0;
        dav       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Directed bench for vga_layer_arbiter: driver pushes hand-computed expectations,
// a posedge monitor pops one entry per cycle and compares.
module tb_vga_layer_arbiter;
  import vga_layer_arbiter_pkg::*;

  // Entry layout: [10] check pixel, [9:3] {dav,r,g,b}, [2] frame_tick, [1] cfg_ready, [0] cfg_err
  localparam int W = 11;

  localparam logic [5:0] C0 = 6'b00_11_11;
  localparam logic [5:0] C1 = 6'b10_01_00;
  localparam logic [5:0] C2 = 6'b11_00_01;
  localparam logic [5:0] C3 = 6'b01_10_11;
  localparam logic [7:0] P_NONE = 8'b1000_0000;
  localparam logic [7:0] P_SKIP = 8'b0000_0000;
  localparam logic [7:0] PRIO_DEF = 8'b11_10_01_00;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [3:0]  game_state = 4'b0001;
  logic [1:0]  l0_r, l0_g, l0_b, l1_r, l1_g, l1_b, l2_r, l2_g, l2_b, l3_r, l3_g, l3_b;
  logic        l0_dav = 1'b0, l1_dav = 1'b0, l2_dav = 1'b0, l3_dav = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_en = 4'b1111;
  logic [7:0]  cfg_prio = PRIO_DEF;
  logic        blink_en = 1'b0;
  logic [1:0]  r, g, b;
  logic        dav, frame_tick, cfg_err;
  cfg_state_e  state_dbg;

  logic        n_rst = 1'b1;
  logic [3:0]  n_gs = 4'b0001;
  logic        n_blink = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_err = 1'b0;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign l0_r = 2'd0; assign l0_g = 2'd3; assign l0_b = 2'd3;
  assign l1_r = 2'd2; assign l1_g = 2'd1; assign l1_b = 2'd0;
  assign l2_r = 2'd3; assign l2_g = 2'd0; assign l2_b = 2'd1;
  assign l3_r = 2'd1; assign l3_g = 2'd2; assign l3_b = 2'd3;

  always #5 vga_clk = ~vga_clk;

  vga_layer_arbiter dut (
    .vga_clk(vga_clk), .rst(rst), .x(x), .y(y), .game_state(game_state),
    .l0_r(l0_r), .l0_g(l0_g), .l0_b(l0_b), .l0_dav(l0_dav),
    .l1_r(l1_r), .l1_g(l1_g), .l1_b(l1_b), .l1_dav(l1_dav),
    .l2_r(l2_r), .l2_g(l2_g), .l2_b(l2_b), .l2_dav(l2_dav),
    .l3_r(l3_r), .l3_g(l3_g), .l3_b(l3_b), .l3_dav(l3_dav),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_en(cfg_en), .cfg_prio(cfg_prio),
    .blink_en(blink_en), .r(r), .g(g), .b(b), .dav(dav),
    .frame_tick(frame_tick), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  function automatic logic [7:0] pw(input logic [5:0] c);
    return {2'b11, c};
  endfunction

  task automatic drive(input logic [10:0] px, input logic [9:0] py, input logic [3:0] davs,
                       input logic cv, input logic [3:0] en, input logic [7:0] pr,
                       input logic [7:0] pexp);
    logic tick;
    @(negedge vga_clk);
    rst = n_rst; game_state = n_gs; blink_en = n_blink;
    x = px; y = py;
    {l3_dav, l2_dav, l1_dav, l0_dav} = davs;
    cfg_valid = cv; cfg_en = en; cfg_prio = pr;
    tick = !n_rst && (px == 11'd0) && (py == 10'd0);
    exp_q.push_back({pexp[7], pexp[6:0], tick, exp_ready, exp_err});
  endtask

  task automatic pix(input logic [10:0] px, input logic [9:0] py, input logic [3:0] davs,
                     input logic [7:0] pexp);
    drive(px, py, davs, 1'b0, 4'b0000, 8'h00, pexp);
  endtask

  task automatic cfg(input logic [10:0] px, input logic [9:0] py, input logic [3:0] davs,
                     input logic [3:0] en, input logic [7:0] pr, input logic [7:0] pexp);
    drive(px, py, davs, 1'b1, en, pr, pexp);
  endtask

  // One 4-pixel frame; pixels 1..3 carry the expectation, the start pixel optionally.
  task automatic frame(input logic [3:0] davs, input logic [7:0] pexp, input logic chk_start);
    pix(11'd0, 10'd0, davs, chk_start ? pexp : P_SKIP);
    for (int i = 1; i < 4; i++) pix(11'(i), 10'd0, davs, pexp);
  endtask

  always @(posedge vga_clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[10]) begin
        checks++;
        if ({dav, r, g, b} !== e[9:3]) begin
          errors++;
          $display("FAIL pixel: got dav=%0b rgb=%b expected dav=%0b rgb=%b at t=%0t",
                   dav, {r, g, b}, e[9], e[8:3], $time);
        end
      end
      checks++;
      if (frame_tick !== e[2]) begin
        errors++;
        $display("FAIL frame_tick: got %0b expected %0b at t=%0t", frame_tick, e[2], $time);
      end
      checks++;
      if (cfg_ready !== e[1]) begin
        errors++;
        $display("FAIL cfg_ready: got %0b expected %0b at t=%0t", cfg_ready, e[1], $time);
      end
      checks++;
      if (cfg_err !== e[0]) begin
        errors++;
        $display("FAIL cfg_err: got %0b expected %0b at t=%0t", cfg_err, e[0], $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    n_rst = 1'b1;
    pix(11'd5, 10'd5, 4'b1111, P_NONE);
    pix(11'd5, 10'd5, 4'b1111, P_NONE);
    n_rst = 1'b0;

    // Default config: layer 0 beats layer 2; logo state hides the board
    pix(11'd140, 10'd130, 4'b0101, pw(C0));
    pix(11'd140, 10'd130, 4'b0100, pw(C2));
    pix(11'd300, 10'd200, 4'b1000, pw(C3));
    pix(11'd1,   10'd1,   4'b0010, pw(C1));
    n_gs = STATE_LOGO;
    pix(11'd1, 10'd1, 4'b0010, P_NONE);
    pix(11'd1, 10'd1, 4'b0011, pw(C0));
    pix(11'd1, 10'd1, 4'b0110, pw(C2));
    n_gs = 4'b0001;

    // Mid-frame transfer, slot order 2,3,1,0; second word while busy is ignored
    exp_ready = 1'b0;
    cfg(11'd10, 10'd10, 4'b0101, 4'b1111, 8'b00_01_11_10, pw(C0));
    pix(11'd11, 10'd10, 4'b0101, pw(C0));
    cfg(11'd12, 10'd10, 4'b0101, 4'b0000, 8'b00_01_10_11, pw(C0));
    exp_ready = 1'b1;
    pix(11'd0, 10'd0, 4'b0101, pw(C0));
    pix(11'd1, 10'd0, 4'b0101, pw(C2));
    pix(11'd2, 10'd0, 4'b1001, pw(C3));
    pix(11'd3, 10'd0, 4'b0011, pw(C1));

    // Transfer on the frame-start cycle waits a whole frame
    exp_ready = 1'b0;
    cfg(11'd0, 10'd0, 4'b0101, 4'b1111, PRIO_DEF, pw(C2));
    pix(11'd5, 10'd5, 4'b0101, pw(C2));
    pix(11'd6, 10'd5, 4'b0101, pw(C2));
    exp_ready = 1'b1;
    pix(11'd0, 10'd0, 4'b0101, pw(C2));
    pix(11'd1, 10'd0, 4'b0101, pw(C0));

    // Non-permutation priority: default order, enables applied, sticky error
    exp_ready = 1'b0;
    cfg(11'd5, 10'd5, 4'b0000, 4'b1011, 8'b00_00_01_10, P_NONE);
    exp_ready = 1'b1; exp_err = 1'b1;
    pix(11'd0, 10'd0, 4'b0100, pw(C2));
    pix(11'd1, 10'd0, 4'b0100, P_NONE);
    pix(11'd1, 10'd0, 4'b0011, pw(C0));
    exp_ready = 1'b0;
    cfg(11'd5, 10'd5, 4'b0000, 4'b1111, PRIO_DEF, P_NONE);
    exp_ready = 1'b1;
    pix(11'd0, 10'd0, 4'b0100, P_NONE);
    pix(11'd1, 10'd0, 4'b0100, pw(C2));

    // Blink: counter starts at 0 with phase 1, so frames 30..59 are hidden
    n_blink = 1'b1;
    for (int n = 1; n <= 65; n++)
      frame(4'b0100, (n >= 30 && n < 60) ? P_NONE : pw(C2), 1'b0);
    n_blink = 1'b0;
    for (int n = 0; n < 3; n++) frame(4'b0100, pw(C2), 1'b1);
    n_blink = 1'b1;
    for (int m = 1; m <= 31; m++)
      frame(4'b0100, (m >= 30) ? P_NONE : pw(C2), 1'b0);
    n_blink = 1'b0;
    frame(4'b0100, pw(C2), 1'b1);

    // Outside the visible area nothing is shown
    pix(11'd800,  10'd5,   4'b1111, P_NONE);
    pix(11'd5,    10'd600, 4'b1111, P_NONE);
    pix(11'd799,  10'd599, 4'b1111, pw(C0));
    pix(11'd1000, 10'd0,   4'b1111, P_NONE);

    // Reset with a pending config discards it and clears the error
    exp_ready = 1'b0;
    cfg(11'd5, 10'd5, 4'b0000, 4'b0001, 8'b00_01_10_11, P_NONE);
    n_rst = 1'b1; exp_ready = 1'b1; exp_err = 1'b0;
    pix(11'd7, 10'd7, 4'b1111, P_NONE);
    n_rst = 1'b0;
    pix(11'd0, 10'd0, 4'b1111, pw(C0));
    pix(11'd1, 10'd0, 4'b1110, pw(C1));
    pix(11'd2, 10'd0, 4'b1000, pw(C3));

    repeat (3) @(negedge vga_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
